pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the five-stage core. It replaces the hand-written stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. Each instance carries a valid/ready handshake, synchronous flush, optional two-entry skid buffering for a registered `in_ready`, and saturating stall/bubble performance counters. Stage-specific payload fields are packed by the instantiating stage into `in_data`.

---
 rtl/pipe_pkg.sv | 44 ++++
 rtl/pipe_stage_reg_sat_counter.sv | 19 +
 rtl/pipe_stage_reg.sv | 115 +++++++++++
 tb/tb_pipe_stage_reg.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types: per-boundary payload layouts and
// skid-buffer occupancy encodings for pipe_stage_reg.
package pipe_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic [7:0]  ctrl;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic [3:0]  mem_op;
    logic        wb_en;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] wb_data;
    logic [4:0]  rd;
    logic        wb_en;
  } mem_wb_t;

  localparam int IF_ID_W  = $bits(if_id_t);
  localparam int ID_EX_W  = $bits(id_ex_t);
  localparam int EX_MEM_W = $bits(ex_mem_t);
  localparam int MEM_WB_W = $bits(mem_wb_t);

  // Occupancy as {main valid, skid valid}
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_TWO   = 2'b11;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter used for stage stall/bubble statistics.
// Clear wins over increment; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr)
      q <= '0;
    else if (inc && (q != '1))
      q <= q + CNT_W'(1);
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage register: valid/ready handshake, flush,
// optional two-entry skid buffer, stall/bubble counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int W          = 32,
  parameter int SKID       = 1,
  parameter int CLEAR_DATA = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic acc;
  logic emit;

  assign acc  = in_valid && in_ready;
  assign emit = out_valid && out_ready;

  generate
    if (SKID == 0) begin : g_single
      logic         v;
      logic [W-1:0] d;

      assign in_ready  = out_ready || !v;
      assign out_valid = v;
      assign out_data  = d;

      always_ff @(posedge clk) begin
        if (rst || flush) begin
          v <= 1'b0;
          if (CLEAR_DATA != 0) d <= '0;
        end else if (acc) begin
          v <= 1'b1;
          d <= in_data;
        end else if (emit) begin
          v <= 1'b0;
          if (CLEAR_DATA != 0) d <= '0;
        end
      end
    end else begin : g_skid
      logic [1:0]   st;
      logic [W-1:0] md;
      logic [W-1:0] sd;

      // in_ready comes straight from the skid flop: no path from out_ready
      assign in_ready  = !st[0];
      assign out_valid = st[1];
      assign out_data  = md;

      always_ff @(posedge clk) begin
        if (rst || flush) begin
          st <= ST_EMPTY;
          if (CLEAR_DATA != 0) begin
            md <= '0;
            sd <= '0;
          end
        end else begin
          unique case (1'b1)
            !st[1]: begin
              if (acc) begin
                st <= ST_ONE;
                md <= in_data;
              end
            end
            st == ST_ONE: begin
              if (acc && emit) begin
                md <= in_data;
              end else if (acc) begin
                st <= ST_TWO;
                sd <= in_data;
              end else if (emit) begin
                st <= ST_EMPTY;
                if (CLEAR_DATA != 0) md <= '0;
              end
            end
            st == ST_TWO: begin
              if (emit) begin
                st <= ST_ONE;
                md <= sd;
                if (CLEAR_DATA != 0) sd <= '0;
              end
            end
          endcase
        end
      end
    end
  endgenerate

  sat_counter #(.CNT_W(CNT_W)) u_stall (
    .clk (clk),
    .clr (rst || cnt_clr),
    .inc (out_valid && !out_ready),
    .q   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble (
    .clk (clk),
    .clr (rst || cnt_clr),
    .inc (!out_valid && out_ready),
    .q   (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: skid, single-register
// and narrow-counter instances driven by directed vectors.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] q1[$];
  logic [31:0] q0[$];

  // u1: SKID=1, W=32
  logic        flush1, iv1, ir1, ov1, or1, clr1;
  logic [31:0] id1, od1;
  logic [15:0] sc1, bc1;
  // u0: SKID=0, W=32
  logic        flush0, iv0, ir0, ov0, or0, clr0;
  logic [31:0] id0, od0;
  logic [15:0] sc0, bc0;
  // u3: SKID=1, W=8, CNT_W=3
  logic        flush3, iv3, ir3, ov3, or3, clr3;
  logic [7:0]  id3, od3;
  logic [2:0]  sc3, bc3;

  pipe_stage_reg #(.W(32), .SKID(1), .CLEAR_DATA(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .flush(flush1),
    .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1),
    .cnt_clr(clr1), .stall_cnt(sc1), .bubble_cnt(bc1)
  );

  pipe_stage_reg #(.W(32), .SKID(0), .CLEAR_DATA(1), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .flush(flush0),
    .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0),
    .cnt_clr(clr0), .stall_cnt(sc0), .bubble_cnt(bc0)
  );

  pipe_stage_reg #(.W(8), .SKID(1), .CLEAR_DATA(1), .CNT_W(3)) u3 (
    .clk(clk), .rst(rst), .flush(flush3),
    .in_valid(iv3), .in_ready(ir3), .in_data(id3),
    .out_valid(ov3), .out_ready(or3), .out_data(od3),
    .cnt_clr(clr3), .stall_cnt(sc3), .bubble_cnt(bc3)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ov1 && or1) begin
      if (q1.size() == 0) begin
        chk("u1_unexpected_beat", od1, 32'hxxxx_xxxx);
      end else begin
        chk("u1_emit_data", od1, q1.pop_front());
      end
    end
    if (!rst && ov0 && or0) begin
      if (q0.size() == 0) begin
        chk("u0_unexpected_beat", od0, 32'hxxxx_xxxx);
      end else begin
        chk("u0_emit_data", od0, q0.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    {flush1, iv1, or1, clr1} = '0; id1 = '0;
    {flush0, iv0, or0, clr0} = '0; id0 = '0;
    {flush3, iv3, clr3} = '0; or3 = 1'b1; id3 = '0;
    step(2);
    rst = 1'b0;
    #1;
    chk("rst_ov1", 32'(ov1), 32'd0);
    chk("rst_od1", od1, 32'd0);
    chk("rst_ir1", 32'(ir1), 32'd1);
    chk("rst_sc1", 32'(sc1), 32'd0);
    chk("rst_bc1", 32'(bc1), 32'd0);
    chk("rst_ov0", 32'(ov0), 32'd0);
    chk("rst_od0", od0, 32'd0);

    // 1: back-to-back flow through skid stage
    or1 = 1'b1;
    q1.push_back(32'h11);
    q1.push_back(32'h22);
    q1.push_back(32'h33);
    iv1 = 1'b1; id1 = 32'h11;
    step();
    #1;
    chk("t1_latency_ov", 32'(ov1), 32'd1);
    chk("t1_latency_od", od1, 32'h11);
    chk("t1_ir_a", 32'(ir1), 32'd1);
    id1 = 32'h22;
    step();
    #1;
    chk("t1_ir_b", 32'(ir1), 32'd1);
    id1 = 32'h33;
    step();
    #1;
    chk("t1_ir_c", 32'(ir1), 32'd1);
    iv1 = 1'b0;
    step(2);

    // 2: fill to TWO with downstream stalled, then drain
    or1 = 1'b0;
    q1.push_back(32'hA);
    q1.push_back(32'hB);
    iv1 = 1'b1; id1 = 32'hA;
    step();
    id1 = 32'hB;
    step();
    iv1 = 1'b0;
    #1;
    chk("t2_ir_full", 32'(ir1), 32'd0);
    chk("t2_od_hold", od1, 32'hA);
    step(2);
    chk("t2_od_stable", od1, 32'hA);
    or1 = 1'b1;
    step(2);
    #1;
    chk("t2_drained", 32'(ov1), 32'd0);

    // 3: flush while in TWO with a simultaneous offer
    or1 = 1'b0;
    iv1 = 1'b1; id1 = 32'h5A;
    step();
    id1 = 32'h5B;
    step();
    flush1 = 1'b1; id1 = 32'hC;
    step();
    flush1 = 1'b0; iv1 = 1'b0;
    #1;
    chk("t3_ov", 32'(ov1), 32'd0);
    chk("t3_od", od1, 32'd0);
    chk("t3_ir", 32'(ir1), 32'd1);
    or1 = 1'b1;
    step(2);

    // 4: single-register stall counting and clear
    or0 = 1'b0;
    iv0 = 1'b1; id0 = 32'hDEAD_BEEF;
    step();
    iv0 = 1'b0;
    #1;
    chk("t4_ir_stalled", 32'(ir0), 32'd0);
    step(5);
    chk("t4_stall5", 32'(sc0), 32'd5);
    chk("t4_od_stable", od0, 32'hDEAD_BEEF);
    chk("t4_ov", 32'(ov0), 32'd1);
    or0 = 1'b1;
    #1;
    chk("t4_ir_comb", 32'(ir0), 32'd1);
    or0 = 1'b0;
    clr0 = 1'b1;
    step();
    clr0 = 1'b0;
    chk("t4_cleared", 32'(sc0), 32'd0);

    // 5: bubble counter saturation at CNT_W=3
    clr3 = 1'b1;
    step();
    clr3 = 1'b0;
    chk("t5_start", 32'(bc3), 32'd0);
    step(5);
    chk("t5_five", 32'(bc3), 32'd5);
    step(5);
    chk("t5_sat", 32'(bc3), 32'd7);

    // 6: reset with both stages full
    or1 = 1'b0;
    iv1 = 1'b1; id1 = 32'h77;
    step();
    id1 = 32'h88;
    step();
    iv1 = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("t6_ov1", 32'(ov1), 32'd0);
    chk("t6_od1", od1, 32'd0);
    chk("t6_ir1", 32'(ir1), 32'd1);
    chk("t6_sc1", 32'(sc1), 32'd0);
    chk("t6_ov0", 32'(ov0), 32'd0);
    chk("t6_od0", od0, 32'd0);
    chk("t6_sc0", 32'(sc0), 32'd0);
    chk("t6_bc0", 32'(bc0), 32'd0);
    or1 = 1'b1; or0 = 1'b1;
    q1.push_back(32'h99);
    q0.push_back(32'h66);
    q0.push_back(32'h1);
    q0.push_back(32'h2);
    iv1 = 1'b1; id1 = 32'h99;
    iv0 = 1'b1; id0 = 32'h66;
    step();
    iv1 = 1'b0;
    #1;
    chk("t6_lat_ov1", 32'(ov1), 32'd1);
    chk("t6_lat_od1", od1, 32'h99);
    chk("t6_lat_ov0", 32'(ov0), 32'd1);
    chk("t6_lat_od0", od0, 32'h66);
    id0 = 32'h1;
    step();
    id0 = 32'h2;
    step();
    iv0 = 1'b0;
    step(3);

    chk("q1_empty", 32'(q1.size()), 32'd0);
    chk("q0_empty", 32'(q0.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
